// File: rtl/id_decode_regfile.sv
// id_decode_regfile: decode stage with bypassed 16x16 register file, load-use stall and RUN/HALT control
module id_decode_regfile #(
  parameter int NREGS = 16,
  parameter int DW = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                instr_ID,
  input  logic                       instrValid_ID,
  input  logic                       wbEn,
  input  logic [$clog2(NREGS)-1:0]   wbReg,
  input  logic [DW-1:0]              wbData,
  input  logic                       memRead_EX,
  input  logic [$clog2(NREGS)-1:0]   dstReg_EX,
  output logic [DW-1:0]              regData1_ID,
  output logic [DW-1:0]              regData2_ID,
  output logic                       writeReg_ID,
  output logic                       regSel_ID,
  output logic                       stall,
  output logic                       halted
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, nextState;
  logic [DW-1:0] regs [NREGS];
  logic [3:0] opcode;
  logic [AW-1:0] rd, rs, rt, idx1, idx2;
  logic isAlu, isLw, isSw, isLl, isHalt, use1, use2, writes, wbHit;
  assign opcode = instr_ID[15:12];
  assign rd = instr_ID[11:8];
  assign rs = instr_ID[7:4];
  assign rt = instr_ID[3:0];
  assign isAlu = ~opcode[3];
  assign isLw = opcode == 4'h8;
  assign isSw = opcode == 4'h9;
  assign isLl = opcode == 4'hA || opcode == 4'hB;
  assign isHalt = opcode == 4'hF;
  assign use1 = ~isHalt;
  assign use2 = isAlu | isSw;
  assign writes = isAlu | isLw | isLl;
  assign idx1 = isLl ? rd : rs;
  assign idx2 = isSw ? rd : rt;
  assign wbHit = wbEn && wbReg != '0;
  // Same-cycle writeback is forwarded so decode never sees a stale value
  assign regData1_ID = (wbHit && wbReg == idx1) ? wbData : (idx1 == '0 ? '0 : regs[idx1]);
  assign regData2_ID = (wbHit && wbReg == idx2) ? wbData : (idx2 == '0 ? '0 : regs[idx2]);
  assign halted = ~rst && state == HALT;
  assign stall = ~rst && memRead_EX && dstReg_EX != '0 && instrValid_ID && state == RUN &&
                 ((use1 && dstReg_EX == idx1) || (use2 && dstReg_EX == idx2));
  assign writeReg_ID = ~rst && instrValid_ID && ~stall && state == RUN && writes;
  assign regSel_ID = writeReg_ID && isLw;
  always_comb begin
    nextState = state;
    if (state == RUN && instrValid_ID && isHalt && !stall) nextState = HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= nextState;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wbHit) begin
      regs[wbReg] <= wbData;
    end
  end
endmodule
